date_counter: RTL
=================

DATE_COUNTER -- requirements
Module: date_counter

Interface
REQ-001 Parameter RST_YEAR, default 16'h2000, BCD year loaded at reset.
REQ-002 Parameter RST_MONTH, default 8'h01, BCD month loaded at reset.
REQ-003 Parameter RST_DAY, default 8'h01, BCD day loaded at reset.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 day_tick  input  1  single-cycle pulse from time-of-day counter at 23:59:59 -> 00:00:00 rollover.
REQ-007 load  input  1  single-cycle pulse from the date-setting stage requesting a load of the set values.
REQ-008 year_set3..year_set0  input  4 each  BCD year to load, thousands to units.
REQ-009 month_set1, month_set0  input  4 each  BCD month to load.
REQ-010 day_set1, day_set0  input  4 each  BCD day to load.
REQ-011 year3..year0  output  4 each  current BCD year, registered.
REQ-012 month1, month0  output  4 each  current BCD month, registered.
REQ-013 day1, day0  output  4 each  current BCD day, registered.
REQ-014 leap  output  1  current year is a leap year, registered.
REQ-015 month_end  output  1  one-cycle pulse when a day_tick rolls the month.
REQ-016 load_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-017 All digit outputs SHALL always hold valid BCD (0-9); the date SHALL always be a legal calendar date.
REQ-018 On day_tick with load low, the day SHALL advance by one, with outputs updated on that same clock edge (1-cycle latency from tick sample).
REQ-019 Day increment SHALL be BCD: units 9 -> 0 with tens +1.
REQ-020 Month length: 31 for 01,03,05,07,08,10,12; 30 for 04,06,09,11; 29 for 02 if leap, else 28.
REQ-021 Leap rule: year divisible by 4 and not by 100, or divisible by 400; computed from BCD digits without binary conversion; 2000 leap, 1900 not, 2024 leap, 2023 not.
REQ-022 Day at month length on day_tick SHALL go to 01 and the month SHALL advance; month_end SHALL pulse in the following cycle.
REQ-023 Month 12 rollover SHALL go to 01 and the year SHALL increment in BCD across all four digits.
REQ-024 Year 9999 rollover SHALL wrap to 0000.
REQ-025 leap SHALL be recomputed whenever the year changes and be valid in the same cycle as the new year outputs.
REQ-026 Load validation: every digit <= 9; month 01-12; day 01 to the month length using the set year's leap status.
REQ-027 A valid load SHALL replace all eight digits on the next edge; a load that fails validation SHALL leave the date unchanged and pulse load_err one cycle later.
REQ-028 Simultaneous load and day_tick: load SHALL win and the tick SHALL be discarded; no month_end.
REQ-029 day_tick held high multiple cycles SHALL advance one day per cycle high (no internal edge detect; the source guarantees single-cycle pulses).
REQ-030 month_end and load_err SHALL never assert in the same cycle.

Reset
REQ-031 rst_n low SHALL asynchronously force the date to RST_YEAR/RST_MONTH/RST_DAY, with leap matching RST_YEAR and month_end=0, load_err=0.
REQ-032 Reset asserted mid-operation (during a tick or load) SHALL override; the first tick/load after release is honoured normally.
REQ-033 Parameter defaults SHALL be a valid date; behaviour for invalid parameters is undefined.

Verification
REQ-034 Load 2024-02-28, tick x2 -> 2024-02-29 then 2024-03-01, leap=1, month_end pulses once after the second tick.
REQ-035 Load 2023-02-28, tick -> 2023-03-01; load 1900-02-29 -> load_err pulse, date unchanged; load 2000-02-29 -> accepted, leap=1.
REQ-036 Load 9999-12-31, tick -> 0000-01-01, month_end pulses, leap=1.
REQ-037 Load 2019-12-31, tick -> 2020-01-01; load 2021-13-05 and 2021-04-31 -> each load_err, date held.
REQ-038 load=1 (2030-06-15) with day_tick=1 in the same cycle -> 2030-06-15 exactly, no month_end.
REQ-039 Reset asserted mid-count (e.g. at 2025-07-19) -> immediate 2000-01-01, leap=1; 31 ticks after release -> 2000-02-01.

Source files
------------

// File: rtl/date_counter.sv
// BCD calendar date counter: advances one day per day_tick, accepts validated loads.
// Outputs update on the sampling edge; month_end/load_err are registered one-cycle pulses.
module date_counter #(
  parameter logic [15:0] RST_YEAR  = 16'h2000,
  parameter logic [7:0]  RST_MONTH = 8'h01,
  parameter logic [7:0]  RST_DAY   = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       day_tick,
  input  logic       load,
  input  logic [3:0] year_set3,
  input  logic [3:0] year_set2,
  input  logic [3:0] year_set1,
  input  logic [3:0] year_set0,
  input  logic [3:0] month_set1,
  input  logic [3:0] month_set0,
  input  logic [3:0] day_set1,
  input  logic [3:0] day_set0,
  output logic [3:0] year3,
  output logic [3:0] year2,
  output logic [3:0] year1,
  output logic [3:0] year0,
  output logic [3:0] month1,
  output logic [3:0] month0,
  output logic [3:0] day1,
  output logic [3:0] day0,
  output logic       leap,
  output logic       month_end,
  output logic       load_err
);

  // Two BCD digits divisible by 4: even tens need units 0/4/8, odd tens need 2/6.
  function automatic logic f_div4(input logic [3:0] tens, input logic [3:0] units);
    if (tens[0]) return (units == 4'h2) || (units == 4'h6);
    else         return (units == 4'h0) || (units == 4'h4) || (units == 4'h8);
  endfunction

  // A year ending in 00 is leap only if its century digits are divisible by 4.
  function automatic logic f_is_leap(input logic [15:0] y);
    if (y[7:0] == 8'h00) return f_div4(y[15:12], y[11:8]);
    else                 return f_div4(y[7:4], y[3:0]);
  endfunction

  function automatic logic [7:0] f_month_len(input logic [7:0] m, input logic lp);
    case (m)
      8'h02:                     return lp ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                   return 8'h31;
    endcase
  endfunction

  function automatic logic [7:0] f_bcd2_inc(input logic [7:0] v);
    if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    else                return {v[7:4], v[3:0] + 4'h1};
  endfunction

  function automatic logic [15:0] f_year_inc(input logic [15:0] y);
    logic [15:0] r;
    logic        c;
    r = y;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'h9) begin
          r[4*i +: 4] = 4'h0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'h1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [15:0] r_year;
  logic [7:0]  r_month;
  logic [7:0]  r_day;
  logic        r_leap;
  logic        r_month_end;
  logic        r_load_err;

  logic [15:0] w_set_year;
  logic [7:0]  w_set_month;
  logic [7:0]  w_set_day;
  logic        w_digits_ok;
  logic        w_month_ok;
  logic        w_day_ok;
  logic        w_load_ok;
  logic        w_day_last;
  logic        w_month_last;
  logic [15:0] w_year_inc;

  assign w_set_year  = {year_set3, year_set2, year_set1, year_set0};
  assign w_set_month = {month_set1, month_set0};
  assign w_set_day   = {day_set1, day_set0};

  assign w_digits_ok = (year_set3 <= 4'h9) && (year_set2 <= 4'h9) && (year_set1 <= 4'h9) &&
                       (year_set0 <= 4'h9) && (month_set1 <= 4'h9) && (month_set0 <= 4'h9) &&
                       (day_set1 <= 4'h9) && (day_set0 <= 4'h9);
  assign w_month_ok  = (w_set_month >= 8'h01) && (w_set_month <= 8'h12);
  // Valid BCD compares correctly as plain binary, so the day bound needs no conversion.
  assign w_day_ok    = (w_set_day >= 8'h01) &&
                       (w_set_day <= f_month_len(w_set_month, f_is_leap(w_set_year)));
  assign w_load_ok   = w_digits_ok && w_month_ok && w_day_ok;

  assign w_day_last   = (r_day == f_month_len(r_month, r_leap));
  assign w_month_last = (r_month == 8'h12);
  assign w_year_inc   = f_year_inc(r_year);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_year      <= RST_YEAR;
      r_month     <= RST_MONTH;
      r_day       <= RST_DAY;
      r_leap      <= f_is_leap(RST_YEAR);
      r_month_end <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_month_end <= 1'b0;
      r_load_err  <= 1'b0;
      if (load) begin
        if (w_load_ok) begin
          r_year  <= w_set_year;
          r_month <= w_set_month;
          r_day   <= w_set_day;
          r_leap  <= f_is_leap(w_set_year);
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (day_tick) begin
        if (w_day_last) begin
          r_day       <= 8'h01;
          r_month_end <= 1'b1;
          if (w_month_last) begin
            r_month <= 8'h01;
            r_year  <= w_year_inc;
            r_leap  <= f_is_leap(w_year_inc);
          end else begin
            r_month <= f_bcd2_inc(r_month);
          end
        end else begin
          r_day <= f_bcd2_inc(r_day);
        end
      end
    end
  end

  assign {year3, year2, year1, year0} = r_year;
  assign {month1, month0}             = r_month;
  assign {day1, day0}                 = r_day;
  assign leap                         = r_leap;
  assign month_end                    = r_month_end;
  assign load_err                     = r_load_err;

endmodule
